// File: rtl/led_sel_stepper_if.sv
// Board-control and decoder-drive bundle for led_sel_stepper.
// The board side drives the raw controls; the stepper drives the 3-to-8 decoder inputs.
interface led_sel_stepper_if;
    logic       btn_step;
    logic       sw_en;
    logic       sw_run;
    logic       sw_dir;
    logic [2:0] enable;
    logic [2:0] switch;
    logic       step_pulse;

    modport master (
        output btn_step, sw_en, sw_run, sw_dir,
        input  enable, switch, step_pulse
    );

    modport slave (
        input  btn_step, sw_en, sw_run, sw_dir,
        output enable, switch, step_pulse
    );
endinterface

// File: rtl/led_sel_stepper.sv
// LED index stepper feeding an active-low 3-to-8 decoder.
// Supports manual stepping on debounced presses, a timed running light, and idle.
module led_sel_stepper #(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned CNT_MAX    = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_sel_stepper_if.slave  bus
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TW = $clog2(CNT_MAX);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10
    } state_e;

    // Synchronizer bit order: {btn_step, sw_en, sw_run, sw_dir}
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_lvl_q, deb_lvl_d;
    logic [TW-1:0] tick_q, tick_d;
    state_e        state_q, state_d;
    logic [2:0]    index_q, index_d;
    logic [2:0]    enable_q, enable_d;
    logic          step_pulse_q, step_pulse_d;

    logic btn_s, en_s, run_s, dir_s;
    logic press_s, step_s;

    // Next-state logic: debounce, mode selection, tick counter and index stepping
    always_comb begin
        sync1_d = {bus.btn_step, bus.sw_en, bus.sw_run, bus.sw_dir};
        sync2_d = sync1_q;
        btn_s   = sync2_q[3];
        en_s    = sync2_q[2];
        run_s   = sync2_q[1];
        dir_s   = sync2_q[0];

        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        press_s   = 1'b0;
        if (btn_s != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d = btn_s;
                press_s   = btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_d = '0;
        end

        if (!en_s) begin
            state_d = ST_IDLE;
        end else if (run_s) begin
            state_d = ST_AUTO;
        end else begin
            state_d = ST_MANUAL;
        end

        // A step only happens when the mode is stable, so events coinciding with a mode change are dropped
        tick_d = '0;
        step_s = 1'b0;
        case (state_q)
            ST_MANUAL: begin
                if ((state_d == ST_MANUAL) && press_s) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_AUTO: begin
                if (state_d == ST_AUTO) begin
                    if (tick_q == TICK_LAST) begin
                        step_s = 1'b1;
                        tick_d = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    tick_d = '0;
                end
            end
            default: begin
                tick_d = '0;
                step_s = 1'b0;
            end
        endcase

        if (step_s) begin
            index_d = dir_s ? (index_q - 3'd1) : (index_q + 3'd1);
        end else begin
            index_d = index_q;
        end

        enable_d     = (state_d != ST_IDLE) ? 3'b100 : 3'b000;
        step_pulse_d = step_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 4'b0000;
            sync2_q      <= 4'b0000;
            deb_cnt_q    <= '0;
            deb_lvl_q    <= 1'b0;
            tick_q       <= '0;
            state_q      <= ST_IDLE;
            index_q      <= 3'd0;
            enable_q     <= 3'b000;
            step_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_lvl_q    <= deb_lvl_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            index_q      <= index_d;
            enable_q     <= enable_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign bus.enable     = enable_q;
    assign bus.switch     = index_q;
    assign bus.step_pulse = step_pulse_q;

endmodule
